// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side supplies operands and the start request; the slave side
// (the subtractor) returns status and the parallel result.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  bout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output bout
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor cell is fed from the LSBs of two right-shifting
// operand registers; the borrow is carried between bits in a register.
// The result shifts in from the MSB side so that after WIDTH bits the
// difference is aligned in diff_q without any final reordering.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Full-subtractor cell on the current operand LSBs.
    logic d_bit;
    logic br_next;
    logic last_bit;

    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State and datapath registers; reset clears everything so an aborted
    // operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update: capture in IDLE, one bit per cycle in
    // RUN, a single-cycle DONE before returning to IDLE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    bout_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    bout_d  = br_next;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 scenarios plus an exhaustive
// WIDTH=4 back-to-back sweep, all checked against arithmetic expectations.
module tb_serial_sub;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub_if #(.WIDTH(8)) bus8 ();
    serial_sub_if #(.WIDTH(4)) bus4 ();

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_sub #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic.
    function automatic logic [7:0] ref_diff8(input int unsigned av, input int unsigned bv);
        return 8'((av + 256 - bv) % 256);
    endfunction

    function automatic logic ref_bout(input int unsigned av, input int unsigned bv);
        return (av < bv);
    endfunction

    // Runs one WIDTH=8 operation and records what was observed.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           output logic [7:0] d, output logic bo,
                           output int busy_cnt, output int done_cnt, output int done_idx,
                           output logic [7:0] end_d, output logic end_bo);
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        d        = '0;
        bo       = 1'b0;
        @(negedge clk);
        bus8.a     = av;
        bus8.b     = bv;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        for (int i = 0; i < 14; i++) begin
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx = i;
                    d        = bus8.diff;
                    bo       = bus8.bout;
                end
            end
            @(negedge clk);
        end
        end_d  = bus8.diff;
        end_bo = bus8.bout;
    endtask

    task automatic test_op(input string name, input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] d, end_d, exp_d;
        logic       bo, end_bo, exp_bo;
        int         busy_cnt, done_cnt, done_idx;
        exp_d  = ref_diff8(av, bv);
        exp_bo = ref_bout(av, bv);
        run_op8(av, bv, d, bo, busy_cnt, done_cnt, done_idx, end_d, end_bo);
        n_checks++;
        if (busy_cnt !== 8) begin
            n_fail++;
            $display("FAIL %s busy_cycles a=%0d b=%0d got=%0d exp=8", name, av, bv, busy_cnt);
        end
        n_checks++;
        if (done_cnt !== 1 || done_idx !== 8) begin
            n_fail++;
            $display("FAIL %s done_pulse a=%0d b=%0d count=%0d idx=%0d exp count=1 idx=8",
                     name, av, bv, done_cnt, done_idx);
        end
        n_checks++;
        if (d !== exp_d || bo !== exp_bo) begin
            n_fail++;
            $display("FAIL %s result a=%0d b=%0d got diff=%h bout=%b exp diff=%h bout=%b",
                     name, av, bv, d, bo, exp_d, exp_bo);
        end
        n_checks++;
        if (end_d !== exp_d || end_bo !== exp_bo) begin
            n_fail++;
            $display("FAIL %s hold a=%0d b=%0d got diff=%h bout=%b exp diff=%h bout=%b",
                     name, av, bv, end_d, end_bo, exp_d, exp_bo);
        end
    endtask

    task automatic test_reset();
        bus8.start = 1'($urandom);
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        rst_n      = 1'b0;
        #1;
        n_checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_asserted got busy=%b done=%b diff=%h bout=%b exp all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
        repeat (2) @(negedge clk);
        bus8.start = 1'b0;
        rst_n      = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.bout !== 1'b0 ||
            bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_released got busy=%b done=%b diff=%h bout=%b exp all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
    endtask

    task automatic test_basic();
        test_op("basic", 8'd200, 8'd55);
        test_op("borrow", 8'd5, 8'd9);
        test_op("zero_minus_ff", 8'h00, 8'hFF);
        test_op("equal", 8'hA5, 8'hA5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_op("random", 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt = 0;
        logic [7:0] d = '0;
        logic bo = 1'b0;
        @(negedge clk);
        bus8.a     = 8'h80;
        bus8.b     = 8'h01;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                bus8.a     = 8'h00;
                bus8.b     = 8'h00;
                bus8.start = 1'b1;
            end else if (i == 3) begin
                bus8.start = 1'b0;
                bus8.a     = 8'h3C;
                bus8.b     = 8'hC3;
            end
            if (bus8.done) begin
                done_cnt++;
                d  = bus8.diff;
                bo = bus8.bout;
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL ignore_start done_count got=%0d exp=1", done_cnt);
        end
        n_checks++;
        if (d !== ref_diff8(8'h80, 8'h01) || bo !== ref_bout(8'h80, 8'h01)) begin
            n_fail++;
            $display("FAIL ignore_start result got diff=%h bout=%b exp diff=7f bout=0", d, bo);
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        int busy_cnt = 0;
        @(negedge clk);
        bus8.a     = 8'hF0;
        bus8.b     = 8'h0F;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.bout !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset got busy=%b done=%b diff=%h bout=%b exp all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (bus8.done) done_cnt++;
            if (bus8.busy) busy_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (done_cnt !== 0 || busy_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done got done=%0d busy=%0d exp 0 0", done_cnt, busy_cnt);
        end
        test_op("after_abort", 8'd10, 8'd3);
    endtask

    task automatic test_back_to_back8();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        int k = 0;
        int last = 0;
        int n_ops = 5;
        for (int i = 0; i < n_ops; i++) begin
            qa.push_back(8'($urandom));
            qb.push_back(8'($urandom));
        end
        @(negedge clk);
        bus8.a     = qa[0];
        bus8.b     = qb[0];
        bus8.start = 1'b1;
        for (int cyc = 0; cyc < n_ops * 10 + 20 && k < n_ops; cyc++) begin
            @(negedge clk);
            if (bus8.done) begin
                n_checks++;
                if (bus8.diff !== ref_diff8(qa[k], qb[k]) || bus8.bout !== ref_bout(qa[k], qb[k])) begin
                    n_fail++;
                    $display("FAIL b2b8 result a=%0d b=%0d got diff=%h bout=%b exp diff=%h bout=%b",
                             qa[k], qb[k], bus8.diff, bus8.bout,
                             ref_diff8(qa[k], qb[k]), ref_bout(qa[k], qb[k]));
                end
                if (k > 0) begin
                    n_checks++;
                    if (cyc - last !== 10) begin
                        n_fail++;
                        $display("FAIL b2b8 spacing got=%0d exp=10", cyc - last);
                    end
                end
                last = cyc;
                k++;
                if (k < n_ops) begin
                    bus8.a = qa[k];
                    bus8.b = qb[k];
                end
            end
        end
        bus8.start = 1'b0;
        n_checks++;
        if (k !== n_ops) begin
            n_fail++;
            $display("FAIL b2b8 timeout results got=%0d exp=%0d", k, n_ops);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_exhaustive4();
        int order[256];
        int k = 0;
        int last = 0;
        int av, bv;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        @(negedge clk);
        bus4.a     = 4'(order[0] >> 4);
        bus4.b     = 4'(order[0] & 15);
        bus4.start = 1'b1;
        for (int cyc = 0; cyc < 256 * 6 + 40 && k < 256; cyc++) begin
            @(negedge clk);
            if (bus4.done) begin
                av = order[k] >> 4;
                bv = order[k] & 15;
                n_checks++;
                if ({bus4.bout, bus4.diff} !== {1'(av < bv), 4'((av - bv) & 15)}) begin
                    n_fail++;
                    $display("FAIL exh4 result a=%0d b=%0d got bout=%b diff=%h exp bout=%b diff=%h",
                             av, bv, bus4.bout, bus4.diff, av < bv, (av - bv) & 15);
                end
                if (k > 0) begin
                    n_checks++;
                    if (cyc - last !== 6) begin
                        n_fail++;
                        $display("FAIL exh4 spacing a=%0d b=%0d got=%0d exp=6", av, bv, cyc - last);
                    end
                end
                last = cyc;
                k++;
                if (k < 256) begin
                    bus4.a = 4'(order[k] >> 4);
                    bus4.b = 4'(order[k] & 15);
                end
            end
        end
        bus4.start = 1'b0;
        n_checks++;
        if (k !== 256) begin
            n_fail++;
            $display("FAIL exh4 timeout results got=%0d exp=256", k);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        #3;
        test_reset();
        test_basic();
        test_ignore_start();
        test_abort();
        test_random();
        test_back_to_back8();
        test_exhaustive4();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
